// File: rtl/fft_frame_sched.sv
//==============================================================================
// fft_frame_sched
//
// Frame scheduler in front of a streaming FFT pipeline. Accepts complex
// samples from an upstream valid/ready stream, tags each with its in-frame
// address and forwards it to the FFT input one cycle later. After every full
// frame a fixed idle gap is inserted. A new frame only starts while the
// number of frames inside the FFT is below MAX_INFLIGHT. The FFT output is
// re-registered into a result stream, its address sequence is checked, and
// completed frames are counted.
//
// Parameters
//   TOTAL_STAGE   log2 of FFT points (frame length 2**TOTAL_STAGE)
//   CPLX_WIDTH    complex sample width, {re,im}
//   MAX_INFLIGHT  max frames inside the FFT pipeline (1..7)
//   GAP_CYC       idle cycles after each input frame (>=1)
//
// Ports
//   iclk, rst_n                 clock (rising edge), async active-low reset
//   cfg_enable                  frame-start permission, sampled per frame
//   s_valid/s_data/s_ready      upstream sample stream
//   fft_ien/fft_iaddr/fft_idata FFT pipeline input drive
//   fft_oen/fft_oaddr/fft_odata FFT pipeline output
//   m_valid/m_data/m_addr/m_last result stream (no backpressure)
//   busy                        not idle or frames still in flight
//   inflight                    frames currently inside the FFT
//   frames_done                 completed output frames (wraps)
//   err_seq                     sticky output-sequence error
//==============================================================================
module fft_frame_sched #(
    parameter int TOTAL_STAGE  = 4,
    parameter int CPLX_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 2,
    parameter int GAP_CYC      = 2
) (
    input  logic                   iclk,
    input  logic                   rst_n,
    input  logic                   cfg_enable,
    input  logic                   s_valid,
    input  logic [CPLX_WIDTH-1:0]  s_data,
    output logic                   s_ready,
    output logic                   fft_ien,
    output logic [TOTAL_STAGE-1:0] fft_iaddr,
    output logic [CPLX_WIDTH-1:0]  fft_idata,
    input  logic                   fft_oen,
    input  logic [TOTAL_STAGE-1:0] fft_oaddr,
    input  logic [CPLX_WIDTH-1:0]  fft_odata,
    output logic                   m_valid,
    output logic [CPLX_WIDTH-1:0]  m_data,
    output logic [TOTAL_STAGE-1:0] m_addr,
    output logic                   m_last,
    output logic                   busy,
    output logic [2:0]             inflight,
    output logic [15:0]            frames_done,
    output logic                   err_seq
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TOTAL_STAGE-1:0] CNT_LAST = '1;
    localparam logic [GW-1:0]          GAP_END  = GW'(GAP_CYC - 1);
    localparam logic [2:0]             INF_MAX  = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP
    } state_e;

    state_e state_q, state_d;

    logic [TOTAL_STAGE-1:0] in_cnt_q, in_cnt_d;
    logic [TOTAL_STAGE-1:0] out_cnt_q, out_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [2:0]             inflight_q, inflight_d;
    logic [15:0]            frames_q, frames_d;
    logic                   err_q, err_d;

    logic                   fft_ien_q;
    logic [TOTAL_STAGE-1:0] fft_iaddr_q;
    logic [CPLX_WIDTH-1:0]  fft_idata_q;
    logic                   m_valid_q;
    logic [CPLX_WIDTH-1:0]  m_data_q;
    logic [TOTAL_STAGE-1:0] m_addr_q;
    logic                   m_last_q;

    logic xfer;
    logic in_last;
    logic out_last;
    logic inf_inc;
    logic inf_dec;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_enable && (inflight_q < INF_MAX)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // cfg_enable is deliberately ignored here: a started frame
                // always completes.
                if (in_last) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_END) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    //--------------------------------------------------------------------------
    always_comb begin
        s_ready = (state_q == ST_LOAD);
        busy    = (state_q != ST_IDLE) || (inflight_q != '0);
    end

    //--------------------------------------------------------------------------
    // Transfer and frame-boundary events
    //--------------------------------------------------------------------------
    always_comb begin
        xfer     = s_valid && s_ready;
        in_last  = xfer && (in_cnt_q == CNT_LAST);
        out_last = fft_oen && (out_cnt_q == CNT_LAST);
        inf_inc  = in_last;
        // Never decrement below zero; a spurious pulse only flags err_seq.
        inf_dec  = out_last && (inflight_q != '0);
    end

    //--------------------------------------------------------------------------
    // Counter / status next-state
    //--------------------------------------------------------------------------
    always_comb begin
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        gap_cnt_d  = '0;
        inflight_d = inflight_q;
        frames_d   = frames_q;
        err_d      = err_q;

        if (xfer) begin
            in_cnt_d = in_cnt_q + TOTAL_STAGE'(1);
        end

        if (state_q == ST_GAP) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end

        if (fft_oen) begin
            out_cnt_d = out_cnt_q + TOTAL_STAGE'(1);
            if ((fft_oaddr != out_cnt_q) || (inflight_q == '0)) begin
                err_d = 1'b1;
            end
        end

        unique case ({inf_inc, inf_dec})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase

        if (out_last) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            inflight_q <= '0;
            frames_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            inflight_q <= inflight_d;
            frames_q   <= frames_d;
            err_q      <= err_d;
        end
    end

    //--------------------------------------------------------------------------
    // FFT input drive: one cycle after each accepted sample
    //--------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            fft_ien_q   <= 1'b0;
            fft_iaddr_q <= '0;
            fft_idata_q <= '0;
        end else begin
            fft_ien_q <= xfer;
            if (xfer) begin
                fft_iaddr_q <= in_cnt_q;
                fft_idata_q <= s_data;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Result stream: FFT output registered once
    //--------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= fft_oen;
            m_data_q  <= fft_odata;
            m_addr_q  <= fft_oaddr;
            m_last_q  <= out_last;
        end
    end

    assign fft_ien     = fft_ien_q;
    assign fft_iaddr   = fft_iaddr_q;
    assign fft_idata   = fft_idata_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_addr      = m_addr_q;
    assign m_last      = m_last_q;
    assign inflight    = inflight_q;
    assign frames_done = frames_q;
    assign err_seq     = err_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
//==============================================================================
// tb_fft_frame_sched
//
// Directed bench for fft_frame_sched with default parameters (16-point frames,
// MAX_INFLIGHT=2, GAP_CYC=2). Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
//==============================================================================
module tb_fft_frame_sched;

    logic        iclk;
    logic        rst_n;
    logic        cfg_enable;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        fft_ien;
    logic [3:0]  fft_iaddr;
    logic [31:0] fft_idata;
    logic        fft_oen;
    logic [3:0]  fft_oaddr;
    logic [31:0] fft_odata;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_addr;
    logic        m_last;
    logic        busy;
    logic [2:0]  inflight;
    logic [15:0] frames_done;
    logic        err_seq;

    int n_chk  = 0;
    int n_fail = 0;

    fft_frame_sched #(
        .TOTAL_STAGE  (4),
        .CPLX_WIDTH   (32),
        .MAX_INFLIGHT (2),
        .GAP_CYC      (2)
    ) dut (
        .iclk        (iclk),
        .rst_n       (rst_n),
        .cfg_enable  (cfg_enable),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fft_ien     (fft_ien),
        .fft_iaddr   (fft_iaddr),
        .fft_idata   (fft_idata),
        .fft_oen     (fft_oen),
        .fft_oaddr   (fft_oaddr),
        .fft_odata   (fft_odata),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_addr      (m_addr),
        .m_last      (m_last),
        .busy        (busy),
        .inflight    (inflight),
        .frames_done (frames_done),
        .err_seq     (err_seq)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    // All registered/status outputs must be at their reset values.
    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_ready"},     32'(s_ready),     32'd0);
        check({pfx, "_busy"},        32'(busy),        32'd0);
        check({pfx, "_fft_ien"},     32'(fft_ien),     32'd0);
        check({pfx, "_fft_iaddr"},   32'(fft_iaddr),   32'd0);
        check({pfx, "_fft_idata"},   fft_idata,        32'd0);
        check({pfx, "_m_valid"},     32'(m_valid),     32'd0);
        check({pfx, "_m_last"},      32'(m_last),      32'd0);
        check({pfx, "_m_addr"},      32'(m_addr),      32'd0);
        check({pfx, "_m_data"},      m_data,           32'd0);
        check({pfx, "_inflight"},    32'(inflight),    32'd0);
        check({pfx, "_frames_done"}, 32'(frames_done), 32'd0);
        check({pfx, "_err_seq"},     32'(err_seq),     32'd0);
    endtask

    // Offers n samples base, base+1, ... with s_valid held high. Every
    // accepted sample must show up on the FFT input one cycle later with
    // address equal to its position in the frame.
    task automatic feed_frame(input logic [31:0] base, input int n);
        int   i;
        int   budget;
        logic rdy;
        logic [3:0] exp_addr;
        i      = 0;
        budget = 0;
        s_valid = 1'b1;
        s_data  = base;
        while (i < n && budget < 100) begin
            rdy = s_ready;
            step();
            budget++;
            if (rdy) begin
                exp_addr = 4'(i);
                check("in_ien",   32'(fft_ien),   32'd1);
                check("in_iaddr", 32'(fft_iaddr), 32'(exp_addr));
                check("in_idata", fft_idata,      base + 32'(i));
                i++;
                s_data = base + 32'(i);
            end else begin
                check("in_ien_idle", 32'(fft_ien), 32'd0);
            end
        end
        s_valid = 1'b0;
        check("feed_count", 32'(i), 32'(n));
    endtask

    // One FFT output pulse; the result stream must echo it a cycle later.
    task automatic out_pulse(input logic [3:0] a, input logic [31:0] d, input logic exp_last);
        fft_oen   = 1'b1;
        fft_oaddr = a;
        fft_odata = d;
        step();
        fft_oen = 1'b0;
        check("out_m_valid", 32'(m_valid), 32'd1);
        check("out_m_addr",  32'(m_addr),  32'(a));
        check("out_m_data",  m_data,       d);
        check("out_m_last",  32'(m_last),  32'(exp_last));
    endtask

    initial begin
        int cnt;
        int rdy_hi;
        int ien_hi;

        rst_n      = 1'b1;
        cfg_enable = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        fft_oen    = 1'b0;
        fft_oaddr  = '0;
        fft_odata  = '0;
        #1 rst_n = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge iclk);
        #1;
        check_reset_outputs("rst");
        #2 rst_n = 1'b1;
        step();
        check("idle_no_cfg_ready", 32'(s_ready), 32'd0);

        // ---------------- one full frame, then the gap ----------------
        cfg_enable = 1'b1;
        feed_frame(32'hA000_0000, 16);
        check("f1_ready_after",  32'(s_ready),  32'd0);
        check("f1_inflight",     32'(inflight), 32'd1);
        check("f1_busy",         32'(busy),     32'd1);
        // s_ready low for 2 GAP cycles plus the IDLE cycle before reload
        cnt = 0;
        while (!s_ready && cnt < 20) begin
            step();
            cnt++;
        end
        check("gap_len", 32'(cnt), 32'd3);

        // ---------------- inflight limit ----------------
        feed_frame(32'hB000_0000, 16);
        check("f2_inflight", 32'(inflight), 32'd2);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_0000;
        rdy_hi  = 0;
        ien_hi  = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (s_ready) rdy_hi++;
            if (fft_ien) ien_hi++;
        end
        s_valid = 1'b0;
        check("lim_ready_cycles", 32'(rdy_hi),   32'd0);
        check("lim_ien_cycles",   32'(ien_hi),   32'd0);
        check("lim_inflight",     32'(inflight), 32'd2);
        check("lim_busy",         32'(busy),     32'd1);

        // ---------------- one full output frame ----------------
        check("o1_m_valid_before", 32'(m_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            out_pulse(4'(k), 32'h5000_0000 + 32'(k), (k == 15));
            if (k == 14) check("o1_inflight_mid", 32'(inflight), 32'd2);
        end
        check("o1_frames_done", 32'(frames_done), 32'd1);
        check("o1_inflight",    32'(inflight),    32'd1);
        check("o1_err_seq",     32'(err_seq),     32'd0);
        step();
        check("o1_m_valid_after", 32'(m_valid), 32'd0);

        // ---------------- last in and last out in the same cycle ----------------
        for (int k = 0; k < 15; k++) begin
            out_pulse(4'(k), 32'h6000_0000 + 32'(k), 1'b0);
        end
        feed_frame(32'hC000_0000, 15);
        check("sim_ready", 32'(s_ready), 32'd1);
        s_valid   = 1'b1;
        s_data    = 32'hC000_000F;
        fft_oen   = 1'b1;
        fft_oaddr = 4'd15;
        fft_odata = 32'h6000_000F;
        step();
        s_valid = 1'b0;
        fft_oen = 1'b0;
        check("sim_inflight",    32'(inflight),    32'd1);
        check("sim_ien",         32'(fft_ien),     32'd1);
        check("sim_iaddr",       32'(fft_iaddr),   32'd15);
        check("sim_m_last",      32'(m_last),      32'd1);
        check("sim_frames_done", 32'(frames_done), 32'd2);
        check("sim_err_seq",     32'(err_seq),     32'd0);

        // ---------------- output address sequence error ----------------
        out_pulse(4'd0, 32'h7000_0000, 1'b0);
        out_pulse(4'd1, 32'h7000_0001, 1'b0);
        check("seq_err_before", 32'(err_seq), 32'd0);
        out_pulse(4'd3, 32'h7000_0003, 1'b0);
        check("seq_err_set", 32'(err_seq), 32'd1);
        repeat (5) step();
        check("seq_err_sticky",   32'(err_seq),  32'd1);
        check("seq_err_inflight", 32'(inflight), 32'd1);

        // ---------------- reset mid-frame ----------------
        feed_frame(32'hD000_0000, 7);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #2 rst_n = 1'b1;
        step();

        // output pulse with nothing in flight
        out_pulse(4'd0, 32'h8000_0000, 1'b0);
        check("uf_err_seq",  32'(err_seq),  32'd1);
        check("uf_inflight", 32'(inflight), 32'd0);

        // next frame restarts at address 0
        feed_frame(32'hE000_0000, 16);
        check("post_rst_inflight", 32'(inflight), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 SHALL have parameter TOTAL_STAGE, default 4, meaning log2 of FFT points (16 points).
REQ-002 SHALL have parameter CPLX_WIDTH, default 32, meaning complex sample width ({re,im}).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 2, meaning max frames inside FFT pipeline (1..7).
REQ-004 SHALL have parameter GAP_CYC, default 2, meaning idle cycles inserted after each input frame (>=1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: iclk  in  1  clock, all logic on rising edge; rst_n  in  1  async active-low reset.
REQ-006 SHALL have port cfg_enable  in  1  frame-start permission, sampled per frame.
REQ-007 SHALL have ports s_valid  in  1, s_data  in  CPLX_WIDTH, s_ready  out  1: upstream sample stream; transfer when s_valid&&s_ready.
REQ-008 SHALL have ports fft_ien  out  1, fft_iaddr  out  TOTAL_STAGE, fft_idata  out  CPLX_WIDTH: drive to the FFT pipeline input.
REQ-009 SHALL have ports fft_oen  in  1, fft_oaddr  in  TOTAL_STAGE, fft_odata  in  CPLX_WIDTH: FFT pipeline output.
REQ-010 SHALL have ports m_valid  out  1, m_data  out  CPLX_WIDTH, m_addr  out  TOTAL_STAGE, m_last  out  1: result stream (no backpressure).
REQ-011 SHALL have ports busy  out  1, inflight  out  3, frames_done  out  16, err_seq  out  1 (sticky).

Function
REQ-012 SHALL implement FSM IDLE/LOAD/GAP; s_ready=1 only in LOAD (decoded from state register).
REQ-013 IDLE->LOAD SHALL occur when cfg_enable=1 and inflight<MAX_INFLIGHT; else stay IDLE.
REQ-014 In LOAD, each transfer SHALL register fft_ien=1, fft_iaddr=in_cnt, fft_idata=s_data on the next cycle (latency 1); fft_ien=0 in cycles without transfer.
REQ-015 in_cnt SHALL increment per transfer, wrap from 2^TOTAL_STAGE-1 to 0; the transfer at in_cnt=2^TOTAL_STAGE-1 SHALL move LOAD->GAP.
REQ-016 s_valid gaps in LOAD SHALL stall the frame (no timeout); in_cnt holds.
REQ-017 cfg_enable deassert in LOAD SHALL NOT abort the frame; it only blocks the next IDLE->LOAD.
REQ-018 GAP SHALL last exactly GAP_CYC cycles, then IDLE.
REQ-019 inflight SHALL +1 on last input transfer, -1 on fft_oen with out_cnt=2^TOTAL_STAGE-1; both in same cycle -> unchanged.
REQ-020 out_cnt SHALL track expected output address, +1 per fft_oen with wrap; fft_oaddr!=out_cnt while fft_oen SHALL set err_seq (sticky to reset); out_cnt still increments.
REQ-021 m_valid/m_data/m_addr SHALL be fft_oen/fft_odata/fft_oaddr registered 1 cycle; m_last=1 with m_valid when out_cnt was 2^TOTAL_STAGE-1.
REQ-022 frames_done SHALL +1 per m_last, wrapping 0xFFFF->0.
REQ-023 busy SHALL be 1 when state!=IDLE or inflight!=0.
REQ-024 Output pulse with inflight=0 SHALL set err_seq and leave inflight at 0 (no underflow).

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, in_cnt=out_cnt=0, inflight=0, frames_done=0, err_seq=0, fft_ien=0, fft_iaddr=0, fft_idata=0, m_valid=0, m_last=0, m_addr=0, m_data=0; s_ready=0, busy=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, first accepted sample SHALL get fft_iaddr=0.

Verification
REQ-027 cfg_enable=1, 16 continuous samples -> fft_ien high 16 cycles, fft_iaddr 0..15, each 1 cycle after transfer; s_ready low for 2 GAP cycles; inflight=1.
REQ-028 MAX_INFLIGHT=2, no fft_oen, 3 frames offered -> only 32 samples accepted, s_ready stays 0, inflight=2, busy=1.
REQ-029 Drive fft_oen 16 cycles, fft_oaddr 0..15 -> m_valid 16 cycles delayed 1, m_last on 16th, frames_done=1, inflight decrements, err_seq=0.
REQ-030 Last input transfer and last output pulse same cycle with inflight=1 -> inflight stays 1.
REQ-031 fft_oaddr sequence 0,1,3 -> err_seq=1 on third pulse and stays 1 until rst_n.
REQ-032 rst_n pulsed low after 7 samples -> all outputs 0 immediately; next frame starts fft_iaddr=0, inflight=0.
